// File: rtl/branch_predictor_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : branch_predictor_pkg
//  Description : Shared encodings for the bimodal branch predictor. This
//                package holds the 2-bit saturating counter codes, the table
//                clear value and the state codes of the table-initialisation
//                FSM.
//  Revision    : 1.0 - initial release
// ============================================================================
package branch_predictor_pkg;

    // 2-bit saturating counter encodings. Bit 1 is the predicted direction.
    localparam logic [1:0] BP_SNT   = 2'b00;  // strong not-taken
    localparam logic [1:0] BP_WNT   = 2'b01;  // weak not-taken
    localparam logic [1:0] BP_WT    = 2'b10;  // weak taken
    localparam logic [1:0] BP_ST    = 2'b11;  // strong taken
    localparam logic [1:0] BP_CLEAR = BP_WNT; // value written during init

    // States of the table-initialisation FSM.
    typedef enum logic [0:0] {
        BP_INIT  = 1'b0,
        BP_READY = 1'b1
    } bp_state_t;

endpackage : branch_predictor_pkg
`default_nettype wire

// File: rtl/bp_counter_update.sv
`default_nettype none
// ============================================================================
//  Module      : bp_counter_update
//  Description : Combinational next-state function of a 2-bit saturating
//                counter. The counter steps toward the resolved direction,
//                holding at SNT and ST.
//  Ports       : counter      - current counter value
//                taken        - resolved branch direction
//                next_counter - counter value after one step
//  Revision    : 1.0 - initial release
// ============================================================================
module bp_counter_update
    import branch_predictor_pkg::*;
(
    input  logic [1:0] counter,
    input  logic       taken,
    output logic [1:0] next_counter
);

    always_comb begin
        next_counter = counter;
        if (taken) begin
            if (counter != BP_ST) begin
                next_counter = counter + 2'd1;
            end
        end else begin
            if (counter != BP_SNT) begin
                next_counter = counter - 2'd1;
            end
        end
    end

endmodule : bp_counter_update
`default_nettype wire

// File: rtl/branch_predictor.sv
`default_nettype none
// ============================================================================
//  Module      : branch_predictor
//  Description : Bimodal branch history table of 2-bit saturating counters,
//                indexed by pc[INDEX_BITS+1:2] with no tags. After reset an
//                FSM writes WNT into every entry, one entry per cycle, before
//                predictions go live. Lookup is combinational and
//                read-before-write. Training is one saturating step per
//                resolved branch.
//  Optional    : BRANCH_PREDICTOR_PERF_EN adds branch_count / miss_count.
//  Ports       : clk, reset            - clock, synchronous active-high reset
//                if_pc / predict_taken - fetch lookup and its estimation
//                update_valid/pc/taken - EX-stage training port
//                update_miss           - misprediction flag (perf only)
//                init_busy             - high while the table is cleared
//                branch_count / miss_count (perf build only)
//  Revision    : 1.0 - initial release
// ============================================================================
module branch_predictor
    import branch_predictor_pkg::*;
#(
    parameter int XLEN       = 32,
    parameter int INDEX_BITS = 6
) (
    input  logic            clk,
    input  logic            reset,
    input  logic [XLEN-1:0] if_pc,
    output logic            predict_taken,
    input  logic            update_valid,
    input  logic [XLEN-1:0] update_pc,
    input  logic            update_taken,
    input  logic            update_miss,
`ifdef BRANCH_PREDICTOR_PERF_EN
    output logic [31:0]     branch_count,
    output logic [31:0]     miss_count,
`endif
    output logic            init_busy
);

    localparam int c_ENTRIES = 1 << INDEX_BITS;

    logic [1:0]            r_table [c_ENTRIES];
    bp_state_t             r_state;
    logic [INDEX_BITS-1:0] r_init_idx;

    logic [INDEX_BITS-1:0] w_lookup_idx;
    logic [INDEX_BITS-1:0] w_update_idx;
    logic [1:0]            w_next_counter;
    logic                  w_train;

    assign w_lookup_idx = if_pc[INDEX_BITS+1:2];
    assign w_update_idx = update_pc[INDEX_BITS+1:2];
    assign w_train      = (r_state == BP_READY) && update_valid;

    bp_counter_update u_counter_update (
        .counter      (r_table[w_update_idx]),
        .taken        (update_taken),
        .next_counter (w_next_counter)
    );

    // Init FSM: one entry cleared per cycle; the last clear moves to READY.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state    <= BP_INIT;
            r_init_idx <= '0;
        end else if (r_state == BP_INIT) begin
            r_init_idx <= r_init_idx + 1'b1;
            if (r_init_idx == {INDEX_BITS{1'b1}}) begin
                r_state <= BP_READY;
            end
        end
    end

    // Table storage has no reset of its own; the init FSM clears it.
    always_ff @(posedge clk) begin
        if (!reset) begin
            if (r_state == BP_INIT) begin
                r_table[r_init_idx] <= BP_CLEAR;
            end else if (update_valid) begin
                r_table[w_update_idx] <= w_next_counter;
            end
        end
    end

    // The table read sees the pre-update value; a same-index update becomes
    // visible on the following cycle.
    assign predict_taken = (r_state == BP_READY) && r_table[w_lookup_idx][1];
    assign init_busy     = (r_state == BP_INIT);

`ifdef BRANCH_PREDICTOR_PERF_EN
    logic [31:0] r_branch_count;
    logic [31:0] r_miss_count;

    // INIT is entered only through reset, so reset also covers the
    // clear-on-INIT-entry behaviour.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_branch_count <= '0;
            r_miss_count   <= '0;
        end else if (w_train) begin
            r_branch_count <= r_branch_count + 32'd1;
            if (update_miss) begin
                r_miss_count <= r_miss_count + 32'd1;
            end
        end
    end

    assign branch_count = r_branch_count;
    assign miss_count   = r_miss_count;

    logic w_unused_bits;
    assign w_unused_bits = ^{if_pc[XLEN-1:INDEX_BITS+2], if_pc[1:0],
                             update_pc[XLEN-1:INDEX_BITS+2], update_pc[1:0]};
`else
    // Upper PC bits alias by design; update_miss only feeds the perf counters.
    logic w_unused_bits;
    assign w_unused_bits = ^{if_pc[XLEN-1:INDEX_BITS+2], if_pc[1:0],
                             update_pc[XLEN-1:INDEX_BITS+2], update_pc[1:0],
                             update_miss, w_train};
`endif

endmodule : branch_predictor
`default_nettype wire
